// File: rtl/fir_deconvolver.sv
// Inverse of the 4-tap FIR link stage: rebuilds x[n] = y[n] - sum c[k]*x[n-k]
// with a single time-shared multiplier stepping one tap per cycle.

module fir_deconvolver_chk #(
    parameter int W = 16
) (
    input logic         clk,
    input logic         reset_n,
    input logic         clear,
    input logic         in_ready,
    input logic         out_valid,
    input logic         out_ready,
    input logic [W-1:0] out_data
);

    property p_stall_hold;
        @(posedge clk) disable iff (!reset_n)
            (out_valid && !out_ready && !clear) |=> (out_valid && $stable(out_data));
    endproperty

    property p_no_bypass;
        @(posedge clk) disable iff (!reset_n)
            out_valid |-> !in_ready;
    endproperty

    a_stall_hold: assert property (p_stall_hold);
    a_no_bypass:  assert property (p_no_bypass);

endmodule

module fir_deconvolver #(
    parameter int              N      = 4,
    parameter logic [16*N-1:0] COEFFS = {16'sd4, 16'sd3, 16'sd2, 16'sd0},
    parameter int              ACC_W  = 40
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] out_data,
    output logic               out_sat
);

    localparam int TAP_W = $clog2(N);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    function automatic logic signed [15:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [15:0] r;
        if (v > SAT_MAX) begin
            r = 16'sh7fff;
        end else if (v < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    function automatic logic clipped(input logic signed [ACC_W-1:0] v);
        return (v > SAT_MAX) || (v < SAT_MIN);
    endfunction

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic signed [15:0]        hist_q [N-1];
    logic signed [15:0]        hist_d [N-1];
    logic signed [15:0]        out_data_q, out_data_d;
    logic                      out_sat_q, out_sat_d;
    logic                      out_valid_q, out_valid_d;
    logic                      alive_q, alive_d;

    logic                      in_ready_s;
    logic signed [15:0]        coef_s;
    logic signed [15:0]        mac_hist_s;
    logic signed [31:0]        prod_s;
    logic signed [ACC_W-1:0]   acc_sub_s;
    logic signed [15:0]        final_x_s;

    // Tap mux, shared multiply-subtract and FSM next-state.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        hist_d      = hist_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        alive_d     = 1'b1;
        coef_s      = 16'sd0;
        mac_hist_s  = 16'sd0;

        for (int k = 0; k < N - 1; k++) begin
            coef_s     = (tap_q == TAP_W'(k + 1)) ? COEFFS[16*(k+1) +: 16] : coef_s;
            mac_hist_s = (tap_q == TAP_W'(k + 1)) ? hist_q[k] : mac_hist_s;
        end

        prod_s    = coef_s * mac_hist_s;
        acc_sub_s = acc_q - {{(ACC_W-32){prod_s[31]}}, prod_s};
        final_x_s = sat16(acc_sub_s);

        // Ready only once out of reset, in IDLE, and never while flushing.
        in_ready_s = alive_q && (state_q == S_IDLE) && !clear;

        if (clear) begin
            state_d     = S_IDLE;
            acc_d       = '0;
            tap_d       = '0;
            out_valid_d = 1'b0;
            out_sat_d   = 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                hist_d[k] = 16'sd0;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_ready_s) begin
                        acc_d   = {{(ACC_W-32){in_data[31]}}, in_data};
                        tap_d   = TAP_W'(1);
                        state_d = S_MAC;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MAC: begin
                    acc_d = acc_sub_s;
                    if (tap_q == TAP_W'(N - 1)) begin
                        // History keeps the clipped value so the encoder side sees the same sample.
                        out_data_d  = final_x_s;
                        out_sat_d   = clipped(acc_sub_s);
                        out_valid_d = 1'b1;
                        hist_d[0]   = final_x_s;
                        for (int k = 1; k < N - 1; k++) begin
                            hist_d[k] = hist_q[k-1];
                        end
                        tap_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        tap_d   = tap_q + TAP_W'(1);
                        state_d = S_MAC;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end else begin
                        state_d = S_OUT;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            tap_q       <= '0;
            out_data_q  <= 16'sd0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
            alive_q     <= 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                hist_q[k] <= 16'sd0;
            end
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
            alive_q     <= alive_d;
            hist_q      <= hist_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    fir_deconvolver_chk #(
        .W(16)
    ) u_chk (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .in_ready (in_ready_s),
        .out_valid(out_valid_q),
        .out_ready(out_ready),
        .out_data (out_data_q)
    );

endmodule

// File: tb/tb_fir_deconvolver.sv
// Directed and random scoreboard bench for fir_deconvolver (c = 1,2,3,4).

module tb_fir_deconvolver;

    localparam int N = 4;

    typedef struct packed {
        logic        s;
        logic [15:0] d;
    } exp_t;

    logic        clk       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        clear     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [31:0] in_data   = 32'd0;
    logic        rand_mode = 1'b0;
    logic        or_dir    = 1'b1;
    logic        rnd_ready;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_sat;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    assign out_ready = rand_mode ? rnd_ready : or_dir;

    fir_deconvolver #(
        .N(N)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        rnd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rnd_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_x(input logic [15:0] d, input logic s);
        exp_q.push_back({s, d});
    endtask

    task automatic send(input logic [31:0] y, input int gap);
        logic got;
        got = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = y;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            got = in_ready;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        chk("accept", 32'(got), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic no_out(input string tag);
        logic seen;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk(tag, 32'(seen), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every output handshake pops and compares one expected sample.
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            chk("spurious_out", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("x_out", {15'd0, out_sat, out_data}, {15'd0, mon_e.s, mon_e.d});
            end
        end
    end

    initial begin
        int t2_y[7];
        int t2_x[7];
        int t3_y[6];
        int t_acc;
        int x, x1, x2, x3, y;
        logic signed [15:0] xs;

        t2_y = '{1000, 2000, 3000, 4000, 0, 0, 0};
        t2_x = '{1000, 0, 0, 0, 0, 0, 0};
        t3_y = '{500, 1500, 3000, 5000, 5000, 5000};

        // T1: reset held with in_valid high
        in_valid = 1'b1;
        in_data  = 32'd777;
        repeat (3) begin
            @(negedge clk);
            chk("rst_hold", 32'({in_ready, out_valid, out_data}), 32'd0);
        end
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        // T2: impulse
        for (int i = 0; i < 7; i++) begin
            expect_x(16'(t2_x[i]), 1'b0);
            send(32'(t2_y[i]), 0);
        end
        wait_drain();

        // T3: step with latency check
        do_clear();
        for (int i = 0; i < 6; i++) begin
            expect_x(16'd500, 1'b0);
            send(32'(t3_y[i]), 0);
            t_acc = cyc;
            wait_valid("t3_valid");
            chk("t3_latency", 32'(cyc - t_acc), 32'(N - 1));
            @(posedge clk);
            #1;
        end
        wait_drain();

        // T4: backpressure
        do_clear();
        or_dir = 1'b0;
        expect_x(16'd1234, 1'b0);
        send(32'd1234, 0);
        wait_valid("t4_valid");
        repeat (10) begin
            @(negedge clk);
            chk("t4_stall", 32'({out_valid, in_ready, out_data}), 32'({1'b1, 1'b0, 16'd1234}));
        end
        @(posedge clk);
        #1;
        or_dir = 1'b1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("t4_release", 32'({out_valid, in_ready}), 32'd1);
        chk("t4_no_dup", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;

        // T5: saturation both ways
        do_clear();
        expect_x(16'h7fff, 1'b1);
        send(32'd40000, 0);
        expect_x(16'h8000, 1'b1);
        send(32'd0, 0);
        wait_drain();

        // T6a: clear in second MAC cycle
        send(32'd2222, 0);
        @(posedge clk);
        #1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        no_out("t6a_no_out");
        expect_x(16'd1000, 1'b0);
        send(32'd1000, 0);
        wait_drain();

        // T6b: reset pulse in second MAC cycle, after building history
        do_clear();
        expect_x(16'd5000, 1'b0);
        send(32'd5000, 0);
        wait_drain();
        send(32'd3333, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        no_out("t6b_no_out");
        expect_x(16'd1000, 1'b0);
        send(32'd1000, 0);
        wait_drain();

        // Random: x through the forward FIR, with input and output stalls
        do_clear();
        rand_mode = 1'b1;
        x1 = 0;
        x2 = 0;
        x3 = 0;
        for (int i = 0; i < 2000; i++) begin
            xs = 16'($urandom);
            x  = int'(xs);
            y  = x + 2 * x1 + 3 * x2 + 4 * x3;
            expect_x(16'(x), 1'b0);
            send(32'(y), int'($urandom_range(0, 2)));
            x3 = x2;
            x2 = x1;
            x1 = x;
        end
        rand_mode = 1'b0;
        wait_drain();
        chk("drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
